// File: rtl/legv8_ctrl_pkg.sv
// Shared encodings for the LEGv8 multi-cycle control path: states, opcode
// patterns, ALUOp/pc_src/alu_src_b codes and the decoded opcode class.
package legv8_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC_R   = 4'd2,
    WB_R     = 4'd3,
    MEM_ADDR = 4'd4,
    MEM_RD   = 4'd5,
    WB_MEM   = 4'd6,
    MEM_WR   = 4'd7,
    BR_CBZ   = 4'd8,
    BR_UNC   = 4'd9,
    TRAP     = 4'd10
  } state_t;

  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  // CBZ and B only fix their upper bits; the rest belong to the offset field
  localparam logic [7:0]  OP_CBZ_PFX = 8'b10110100;
  localparam logic [5:0]  OP_B_PFX   = 6'b000101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_PASSB = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  localparam logic [1:0] PC_SRC_SEQ = 2'b00;
  localparam logic [1:0] PC_SRC_CBZ = 2'b01;
  localparam logic [1:0] PC_SRC_B   = 2'b10;

  localparam logic [1:0] ALU_SRC_B_REG = 2'b00;
  localparam logic [1:0] ALU_SRC_B_IMM = 2'b10;

  typedef struct packed {
    logic rtype;
    logic ldur;
    logic stur;
    logic cbz;
    logic b;
    logic illegal;
  } op_class_t;

endpackage

// File: rtl/opcode_class_decode.sv
// Combinational opcode classifier: IR[31:21] -> one-hot instruction class.
module opcode_class_decode
  import legv8_ctrl_pkg::*;
(
  input  logic [10:0] opcode,
  output op_class_t   cls
);

  always_comb begin
    cls = '0;
    if (opcode == OP_ADD || opcode == OP_SUB || opcode == OP_AND || opcode == OP_ORR)
      cls.rtype = 1'b1;
    else if (opcode == OP_LDUR)
      cls.ldur = 1'b1;
    else if (opcode == OP_STUR)
      cls.stur = 1'b1;
    else if (opcode[10:3] == OP_CBZ_PFX)
      cls.cbz = 1'b1;
    else if (opcode[10:5] == OP_B_PFX)
      cls.b = 1'b1;
    else
      cls.illegal = 1'b1;
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// LEGv8 multi-cycle sequencer: walks each instruction through fetch/decode/
// execute/memory/writeback and traps on illegal opcodes or memory timeouts.
module multicycle_control_fsm
  import legv8_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 255,
  parameter int unsigned CNT_W      = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] opcode,
  input  logic        alu_zero,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        ir_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic [1:0]  alu_op,
  output logic [1:0]  alu_src_b,
  output logic        reg2_loc,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        retire,
  output logic        illegal,
  output logic        bus_err,
  output logic [3:0]  state_dbg
);

  // Memory handshake: a request (mem_read/mem_write) is held steady until the
  // cycle mem_ready=1, which completes the access on that rising edge.
  state_t            state, state_nxt;
  op_class_t         cls;
  logic [CNT_W-1:0]  wait_cnt;
  logic              is_load;
  logic              wait_hit;
  logic              illegal_set;
  logic              bus_err_set;

  opcode_class_decode u_decode (
    .opcode (opcode),
    .cls    (cls)
  );

  // mem_ready arriving in the limit cycle still completes normally
  assign wait_hit  = !mem_ready && (wait_cnt == CNT_W'(WAIT_LIMIT - 1));
  assign state_dbg = state;

  always_comb begin
    state_nxt   = state;
    illegal_set = 1'b0;
    bus_err_set = 1'b0;
    pc_write    = 1'b0;
    pc_src      = PC_SRC_SEQ;
    ir_write    = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    alu_op      = ALUOP_ADD;
    alu_src_b   = ALU_SRC_B_REG;
    reg2_loc    = 1'b0;
    reg_write   = 1'b0;
    mem_to_reg  = 1'b0;
    retire      = 1'b0;
    case (state)
      FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          state_nxt = DECODE;
        end else if (wait_hit) begin
          bus_err_set = 1'b1;
          state_nxt   = TRAP;
        end
      end
      DECODE: begin
        reg2_loc = cls.stur | cls.cbz;
        if (cls.rtype)                 state_nxt = EXEC_R;
        else if (cls.ldur || cls.stur) state_nxt = MEM_ADDR;
        else if (cls.cbz)              state_nxt = BR_CBZ;
        else if (cls.b)                state_nxt = BR_UNC;
        else begin
          illegal_set = 1'b1;
          state_nxt   = TRAP;
        end
      end
      EXEC_R: begin
        alu_op    = ALUOP_RTYPE;
        state_nxt = WB_R;
      end
      WB_R: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_nxt = FETCH;
      end
      MEM_ADDR: begin
        alu_src_b = ALU_SRC_B_IMM;
        state_nxt = is_load ? MEM_RD : MEM_WR;
      end
      MEM_RD: begin
        mem_read = 1'b1;
        if (mem_ready) state_nxt = WB_MEM;
        else if (wait_hit) begin
          bus_err_set = 1'b1;
          state_nxt   = TRAP;
        end
      end
      WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_nxt  = FETCH;
      end
      MEM_WR: begin
        mem_write = 1'b1;
        reg2_loc  = 1'b1;
        if (mem_ready) begin
          retire    = 1'b1;
          state_nxt = FETCH;
        end else if (wait_hit) begin
          bus_err_set = 1'b1;
          state_nxt   = TRAP;
        end
      end
      BR_CBZ: begin
        alu_op   = ALUOP_PASSB;
        reg2_loc = 1'b1;
        retire   = 1'b1;
        if (alu_zero) begin
          pc_write = 1'b1;
          pc_src   = PC_SRC_CBZ;
        end
        state_nxt = FETCH;
      end
      BR_UNC: begin
        pc_write  = 1'b1;
        pc_src    = PC_SRC_B;
        retire    = 1'b1;
        state_nxt = FETCH;
      end
      TRAP:    state_nxt = TRAP;
      default: state_nxt = TRAP;
    endcase
    // Reset must silence requests immediately, not at the next edge
    if (rst) begin
      pc_write   = 1'b0;
      pc_src     = PC_SRC_SEQ;
      ir_write   = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      alu_op     = ALUOP_ADD;
      alu_src_b  = ALU_SRC_B_REG;
      reg2_loc   = 1'b0;
      reg_write  = 1'b0;
      mem_to_reg = 1'b0;
      retire     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FETCH;
      wait_cnt <= '0;
      is_load  <= 1'b0;
      illegal  <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)
        wait_cnt <= '0;
      else if (!mem_ready && (state == FETCH || state == MEM_RD || state == MEM_WR))
        wait_cnt <= wait_cnt + CNT_W'(1);
      if (state == DECODE)
        is_load <= cls.ldur;
      if (illegal_set) illegal <= 1'b1;
      if (bus_err_set) bus_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm with a short memory timeout (4).
module tb_multicycle_control_fsm;

  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_EXEC_R = 4'd2,
                         S_WB_R = 4'd3, S_MEM_ADDR = 4'd4, S_MEM_RD = 4'd5,
                         S_WB_MEM = 4'd6, S_MEM_WR = 4'd7, S_BR_CBZ = 4'd8,
                         S_BR_UNC = 4'd9, S_TRAP = 4'd10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] opcode = 11'b0;
  logic        alu_zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        pc_write, ir_write, mem_read, mem_write, reg2_loc;
  logic        reg_write, mem_to_reg, retire, illegal, bus_err;
  logic [1:0]  pc_src, alu_op, alu_src_b;
  logic [3:0]  state_dbg;

  int checks   = 0;
  int failures = 0;
  int cnt;

  multicycle_control_fsm #(.WAIT_LIMIT(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .alu_zero(alu_zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .pc_src(pc_src),
    .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
    .alu_op(alu_op), .alu_src_b(alu_src_b), .reg2_loc(reg2_loc),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .retire(retire),
    .illegal(illegal), .bus_err(bus_err), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here, checks ~2ns later
  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    chk("rst_state", 16'(state_dbg), 16'(S_FETCH));
    chk("rst_outs", {pc_write, ir_write, mem_read, mem_write, reg_write, retire, illegal, bus_err}, 16'h0);
    next_cyc();
    rst = 1'b0;
  endtask

  initial begin
    // Reset values
    do_reset();

    // ADD with zero-wait memory: FETCH, DECODE, EXEC_R, WB_R
    opcode = 11'b10001011000; mem_ready = 1'b1; cnt = 0;
    #2 chk("add_c1_state", 16'(state_dbg), 16'(S_FETCH));
    chk("add_c1_fetch", {mem_read, ir_write, pc_write, pc_src, alu_op}, {1'b1, 1'b1, 1'b1, 2'b00, 2'b00});
    cnt += int'(pc_write);
    next_cyc(); #2 chk("add_c2_state", 16'(state_dbg), 16'(S_DECODE));
    cnt += int'(pc_write);
    next_cyc(); #2 chk("add_c3_state", 16'(state_dbg), 16'(S_EXEC_R));
    chk("add_c3_aluop", 16'(alu_op), 16'h2);
    cnt += int'(pc_write);
    next_cyc(); #2 chk("add_c4_state", 16'(state_dbg), 16'(S_WB_R));
    chk("add_c4_wb", {reg_write, retire, mem_to_reg}, 3'b110);
    cnt += int'(pc_write);
    chk("add_pcw_once", 16'(cnt), 16'd1);

    // LDUR with 3 wait cycles in MEM_RD: 8 cycles total
    next_cyc(); opcode = 11'b11111000010;
    #2 chk("ld_c1_state", 16'(state_dbg), 16'(S_FETCH));
    next_cyc(); #2 chk("ld_c2_state", 16'(state_dbg), 16'(S_DECODE));
    next_cyc(); #2 chk("ld_c3_state", 16'(state_dbg), 16'(S_MEM_ADDR));
    chk("ld_c3_addr", {alu_op, alu_src_b}, 4'b0010);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      next_cyc(); mem_ready = (i == 3);
      #2 cnt += int'(mem_read && state_dbg == S_MEM_RD && !mem_write);
    end
    chk("ld_memread_held", 16'(cnt), 16'd4);
    next_cyc(); mem_ready = 1'b1;
    #2 chk("ld_c8_state", 16'(state_dbg), 16'(S_WB_MEM));
    chk("ld_c8_wb", {reg_write, mem_to_reg, retire}, 3'b111);
    next_cyc(); #2 chk("ld_done_fetch", 16'(state_dbg), 16'(S_FETCH));

    // CBZ taken then not taken
    opcode = 11'b10110100101; alu_zero = 1'b1;
    next_cyc(); #2 chk("cbz1_decode", {state_dbg, reg2_loc}, {S_DECODE, 1'b1});
    next_cyc(); #2 chk("cbz1_state", 16'(state_dbg), 16'(S_BR_CBZ));
    chk("cbz1_outs", {pc_write, pc_src, alu_op, reg2_loc, retire}, {1'b1, 2'b01, 2'b01, 1'b1, 1'b1});
    alu_zero = 1'b0;
    next_cyc(); #2 chk("cbz2_fetch", 16'(state_dbg), 16'(S_FETCH));
    next_cyc(); next_cyc(); #2 chk("cbz2_state", 16'(state_dbg), 16'(S_BR_CBZ));
    chk("cbz2_outs", {pc_write, alu_op, reg2_loc, retire}, {1'b0, 2'b01, 1'b1, 1'b1});

    // B unconditional
    opcode = 11'b00010100011;
    next_cyc(); next_cyc(); next_cyc();
    #2 chk("b_state", 16'(state_dbg), 16'(S_BR_UNC));
    chk("b_outs", {pc_write, pc_src, retire}, {1'b1, 2'b10, 1'b1});

    // STUR, then async reset while MEM_WR is waiting
    opcode = 11'b11111000000;
    next_cyc(); next_cyc();
    #2 chk("st_decode_reg2", {state_dbg, reg2_loc}, {S_DECODE, 1'b1});
    next_cyc(); next_cyc(); mem_ready = 1'b0;
    opcode = 11'b00000000000;
    #2 chk("st_memwr", {state_dbg, mem_write, mem_read, reg2_loc}, {S_MEM_WR, 1'b1, 1'b0, 1'b1});
    rst = 1'b1;
    #1 chk("st_rst_async", {mem_write, state_dbg}, {1'b0, S_FETCH});
    next_cyc(); rst = 1'b0;
    #2 chk("st_after_rst", {state_dbg, reg_write, retire, illegal, bus_err}, {S_FETCH, 4'b0000});

    // Illegal opcode traps after DECODE and stays quiet
    opcode = 11'b11111111111; mem_ready = 1'b1;
    next_cyc(); next_cyc();
    #2 chk("ill_state", {state_dbg, illegal}, {S_TRAP, 1'b1});
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      next_cyc();
      #2 cnt += int'(mem_read || mem_write || pc_write || reg_write);
    end
    chk("ill_quiet", 16'(cnt), 16'd0);
    chk("ill_stuck", 16'(state_dbg), 16'(S_TRAP));
    do_reset();
    #2 chk("ill_cleared", {state_dbg, illegal}, {S_FETCH, 1'b0});

    // Memory timeout in FETCH after 4 wait cycles
    mem_ready = 1'b0;
    next_cyc(); next_cyc();
    #2 chk("to_waiting", {state_dbg, bus_err, mem_read}, {S_FETCH, 1'b0, 1'b1});
    next_cyc(); next_cyc();
    #2 chk("to_trap", {state_dbg, bus_err}, {S_TRAP, 1'b1});
    do_reset();

    // mem_ready on the 4th wait cycle wins over the timeout
    opcode = 11'b10001011000; mem_ready = 1'b0;
    next_cyc(); next_cyc(); next_cyc(); mem_ready = 1'b1;
    #2 chk("lim_ready_irw", {state_dbg, ir_write}, {S_FETCH, 1'b1});
    next_cyc();
    #2 chk("lim_ready_decode", {state_dbg, bus_err}, {S_DECODE, 1'b0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Multi-cycle sequencer for the LEGv8 datapath.
- Walks each instruction through fetch, decode, execute, memory and writeback states.
- Drives the 2-bit ALUOp consumed by the ALU control decoder, plus PC, IR, register-file and memory enables.
- Sits between the instruction register opcode field, the shared memory port (ready handshake) and the datapath muxes.

Parameters:
- WAIT_LIMIT, 255, max cycles a memory access may wait for mem_ready before a bus error trap (1..65535).
- CNT_W, 16, width of the memory wait counter; must satisfy 2^CNT_W > WAIT_LIMIT.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- opcode  in  11  IR[31:21], valid from DECODE onward.
- alu_zero  in  1  ALU zero flag (combinational from datapath).
- mem_ready  in  1  memory port completes the current read/write this cycle.
- pc_write  out  1  load PC this cycle.
- pc_src  out  2  00=PC+4, 01=PC+(CBZ offset<<2), 10=PC+(B offset<<2).
- ir_write  out  1  load IR from memory read data.
- mem_read  out  1  memory read request (held until mem_ready).
- mem_write  out  1  memory write request (held until mem_ready).
- alu_op  out  2  00=add, 01=pass-B (CBZ), 10=R-type function select.
- alu_src_b  out  2  00=register B, 10=sign-extended D-format immediate.
- reg2_loc  out  1  1 selects Rt as second read register (STUR, CBZ).
- reg_write  out  1  register-file write enable.
- mem_to_reg  out  1  writeback source: 1=memory data, 0=ALU result.
- retire  out  1  one-cycle pulse when an instruction completes.
- illegal  out  1  sticky: undecodable opcode trapped.
- bus_err  out  1  sticky: memory wait exceeded WAIT_LIMIT.
- state_dbg  out  4  current state encoding.

Behaviour:
- Reset (async assert, sync release): state=FETCH, wait counter=0, illegal=0, bus_err=0. All enables 0, alu_op=00, pc_src=00, alu_src_b=00. First FETCH begins on the first clk edge after release.
- Opcode classes:
  - LDUR 11111000010
  - STUR 11111000000
  - R-type: ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000
  - CBZ 10110100xxx
  - B 000101xxxxx
  - Any other opcode is illegal.
- FETCH: mem_read=1, alu_op=00. ir_write, pc_write (pc_src=00) and the move to DECODE occur only in a cycle with mem_ready=1; ir_write and pc_write are combinational on mem_ready. Otherwise stay.
- DECODE: reg2_loc=1 for STUR/CBZ. Next state by class:
  - R-type -> EXEC_R
  - LDUR/STUR -> MEM_ADDR
  - CBZ -> BR_CBZ
  - B -> BR_UNC
  - illegal -> TRAP
- EXEC_R: alu_op=10, alu_src_b=00 -> WB_R.
- WB_R: reg_write=1, mem_to_reg=0, retire=1 -> FETCH.
- MEM_ADDR: alu_op=00, alu_src_b=10 -> MEM_RD (LDUR) or MEM_WR (STUR).
- MEM_RD: mem_read=1; on mem_ready -> WB_MEM.
- WB_MEM: reg_write=1, mem_to_reg=1, retire=1 -> FETCH.
- MEM_WR: mem_write=1, reg2_loc=1; on mem_ready: retire=1 -> FETCH.
- BR_CBZ: alu_op=01, reg2_loc=1. If alu_zero, pc_write=1 with pc_src=01. retire=1 regardless -> FETCH.
- BR_UNC: pc_write=1, pc_src=10, retire=1 -> FETCH.
- TRAP: terminal. All enables 0, no pc_write or memory request; exit only by rst.
- Minimum latencies with zero-wait memory: R-type 4 cycles, LDUR 5, STUR 4, CBZ 3, B 3.
- Wait counter: cleared on entry to FETCH/MEM_RD/MEM_WR; increments each cycle in those states while mem_ready=0.
  - Reaching WAIT_LIMIT with mem_ready=0 -> TRAP with bus_err=1.
  - mem_ready=1 in the same cycle the limit is reached wins (normal completion).
- mem_read and mem_write are never 1 simultaneously; request signals stay stable while waiting.
- An opcode change outside DECODE has no effect; the class is latched into the state path at DECODE.
- rst mid-wait drops mem_read/mem_write immediately (asynchronous); no partial writeback occurs.

Decomposition:
- Shared package (legv8_ctrl_pkg):
  - state enum (11 states, 4-bit)
  - opcode pattern constants
  - ALUOp encodings (ALUOP_ADD=00, ALUOP_PASSB=01, ALUOP_RTYPE=10)
  - pc_src encodings
- Sub-module opcode_class_decode: combinational, 11-bit opcode -> one-hot class {rtype, ldur, stur, cbz, b, illegal}. Reused by the pipelined core later.

Test Plan:
- ADD 10001011000, mem_ready tied 1 -> states FETCH,DECODE,EXEC_R,WB_R. alu_op=10 in EXEC_R. reg_write=1 and retire=1 at cycle 4. pc_write exactly once.
- LDUR 11111000010, mem_ready low 3 cycles in MEM_RD -> mem_read held 4 cycles. WB_MEM reg_write=1, mem_to_reg=1. Total 8 cycles.
- CBZ 10110100101 with alu_zero=1 then alu_zero=0 -> pc_write with pc_src=01 only in the first case. alu_op=01, reg2_loc=1 both times.
- Opcode 11111111111 -> TRAP after DECODE, illegal=1. No further mem_read after 10 cycles. rst clears it to FETCH.
- WAIT_LIMIT=4, mem_ready held 0 in FETCH -> bus_err=1 and state TRAP after 4 wait cycles. Repeat with mem_ready=1 on cycle 4 -> normal DECODE.
- rst asserted mid MEM_WR -> mem_write falls without waiting for clk. After release the next cycle is FETCH with all outputs at reset values.
